// File: rtl/snake_pkg.sv
// Shared types for the snake game: direction codes, grid defaults and coordinate types.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    localparam int GRID_W_DEF = 16;
    localparam int GRID_H_DEF = 16;
    localparam int X_W_DEF    = $clog2(GRID_W_DEF);
    localparam int Y_W_DEF    = $clog2(GRID_H_DEF);

    typedef logic [X_W_DEF-1:0] coord_x_t;
    typedef logic [Y_W_DEF-1:0] coord_y_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LAP  = 1'b1
    } rd_state_t;

endpackage

// File: rtl/snake_step.sv
// Moves one cell in a direction on a toroidal playfield; combinational.
module snake_step
    import snake_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H)
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  dir_t          dir,
    output logic [XW-1:0] nx,
    output logic [YW-1:0] ny
);

    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

    // Explicit edge compares so non-power-of-two grids wrap correctly too
    always_comb begin
        nx = x;
        ny = y;
        case (dir)
            DIR_RIGHT: nx = (x == X_MAX) ? '0 : x + XW'(1);
            DIR_DOWN:  ny = (y == Y_MAX) ? '0 : y + YW'(1);
            DIR_LEFT:  nx = (x == '0) ? X_MAX : x - XW'(1);
            DIR_UP:    ny = (y == '0) ? Y_MAX : y - YW'(1);
            default: begin
                nx = x;
                ny = y;
            end
        endcase
    end

endmodule

// File: rtl/snake_body_reader.sv
// Walks one lap of the direction shift register (recirculating it) and streams every
// body cell tail-first, flagging the first segment that lands on the query cell.
module snake_body_reader
    import snake_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int DEPTH  = 234,
    parameter int GRID_W = 16,
    parameter int GRID_H = 16,
    parameter int LEN_W  = 8,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [XW-1:0]    tail_x,
    input  logic [YW-1:0]    tail_y,
    input  logic [XW-1:0]    qry_x,
    input  logic [YW-1:0]    qry_y,
    input  logic [WIDTH-1:0] sreg_out,
    output logic [WIDTH-1:0] sreg_in,
    output logic             sreg_step,
    output logic             busy,
    output logic             seg_valid,
    output logic [XW-1:0]    seg_x,
    output logic [YW-1:0]    seg_y,
    output logic             seg_tail,
    output logic             seg_head,
    output logic             done,
    output logic             hit,
    output logic [LEN_W-1:0] hit_idx
);

    localparam int CW = LEN_W + 2;
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(DEPTH + 1);
    localparam logic [LEN_W-1:0] LAST_STEP = LEN_W'(DEPTH);

    rd_state_t        state_reg;
    logic [LEN_W-1:0] cnt_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] seg_idx_reg;
    logic [XW-1:0]    pos_x_reg, qry_x_reg, seg_x_reg;
    logic [YW-1:0]    pos_y_reg, qry_y_reg, seg_y_reg;
    logic             busy_reg, step_reg, seg_valid_reg, seg_tail_reg, seg_head_reg;
    logic             done_reg, hit_reg;
    logic [LEN_W-1:0] hit_idx_reg;

    logic [LEN_W-1:0] len_clamped;
    logic [XW-1:0]    next_x;
    logic [YW-1:0]    next_y;
    logic             entry_valid;
    logic             next_match;

    always_comb begin
        len_clamped = len;
        if (len == '0)
            len_clamped = LEN_W'(1);
        else if (len > LEN_MAX)
            len_clamped = LEN_MAX;
    end

    // Entry DEPTH-c is live when DEPTH-c <= len-2, i.e. c + len >= DEPTH + 2
    assign entry_valid = (CW'(cnt_reg) + CW'(len_reg)) >= CW'(DEPTH + 2);
    assign next_match  = (next_x == qry_x_reg) && (next_y == qry_y_reg);

    snake_step #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_step (
        .x   (pos_x_reg),
        .y   (pos_y_reg),
        .dir (dir_t'(sreg_out)),
        .nx  (next_x),
        .ny  (next_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            len_reg       <= '0;
            seg_idx_reg   <= '0;
            pos_x_reg     <= '0;
            pos_y_reg     <= '0;
            qry_x_reg     <= '0;
            qry_y_reg     <= '0;
            seg_x_reg     <= '0;
            seg_y_reg     <= '0;
            busy_reg      <= 1'b0;
            step_reg      <= 1'b0;
            seg_valid_reg <= 1'b0;
            seg_tail_reg  <= 1'b0;
            seg_head_reg  <= 1'b0;
            done_reg      <= 1'b0;
            hit_reg       <= 1'b0;
            hit_idx_reg   <= '0;
        end else begin
            done_reg      <= 1'b0;
            seg_valid_reg <= 1'b0;
            seg_tail_reg  <= 1'b0;
            seg_head_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg     <= ST_LAP;
                        cnt_reg       <= LEN_W'(1);
                        len_reg       <= len_clamped;
                        seg_idx_reg   <= LEN_W'(1);
                        pos_x_reg     <= tail_x;
                        pos_y_reg     <= tail_y;
                        qry_x_reg     <= qry_x;
                        qry_y_reg     <= qry_y;
                        busy_reg      <= 1'b1;
                        step_reg      <= 1'b1;
                        seg_valid_reg <= 1'b1;
                        seg_tail_reg  <= 1'b1;
                        seg_head_reg  <= (len_clamped == LEN_W'(1));
                        seg_x_reg     <= tail_x;
                        seg_y_reg     <= tail_y;
                        hit_reg       <= (tail_x == qry_x) && (tail_y == qry_y);
                        hit_idx_reg   <= '0;
                    end
                end
                ST_LAP: begin
                    if (entry_valid) begin
                        pos_x_reg     <= next_x;
                        pos_y_reg     <= next_y;
                        seg_x_reg     <= next_x;
                        seg_y_reg     <= next_y;
                        seg_valid_reg <= 1'b1;
                        seg_head_reg  <= (cnt_reg == LAST_STEP);
                        seg_idx_reg   <= seg_idx_reg + LEN_W'(1);
                        // Match is judged on the cell being emitted so the head counts by done
                        if (!hit_reg && next_match) begin
                            hit_reg     <= 1'b1;
                            hit_idx_reg <= seg_idx_reg;
                        end
                    end
                    if (cnt_reg == LAST_STEP) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        step_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + LEN_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign sreg_in   = step_reg ? sreg_out : '0;
    assign sreg_step = step_reg;
    assign busy      = busy_reg;
    assign seg_valid = seg_valid_reg;
    assign seg_x     = seg_x_reg;
    assign seg_y     = seg_y_reg;
    assign seg_tail  = seg_tail_reg;
    assign seg_head  = seg_head_reg;
    assign done      = done_reg;
    assign hit       = hit_reg;
    assign hit_idx   = hit_idx_reg;

endmodule

// File: tb/tb_snake_body_reader.sv
// Scoreboard bench for snake_body_reader with a behavioural direction shift register.
module tb_snake_body_reader;

    localparam int WIDTH  = 2;
    localparam int DEPTH  = 234;
    localparam int GRID_W = 16;
    localparam int GRID_H = 16;
    localparam int LEN_W  = 8;
    localparam int XW     = 4;
    localparam int YW     = 4;

    logic             clk, rst, start;
    logic [LEN_W-1:0] len;
    logic [XW-1:0]    tail_x, qry_x, seg_x;
    logic [YW-1:0]    tail_y, qry_y, seg_y;
    logic [WIDTH-1:0] sreg_out, sreg_in;
    logic             sreg_step, busy, seg_valid, seg_tail, seg_head, done, hit;
    logic [LEN_W-1:0] hit_idx;

    snake_body_reader #(
        .WIDTH (WIDTH), .DEPTH (DEPTH), .GRID_W (GRID_W), .GRID_H (GRID_H), .LEN_W (LEN_W)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .len (len),
        .tail_x (tail_x), .tail_y (tail_y), .qry_x (qry_x), .qry_y (qry_y),
        .sreg_out (sreg_out), .sreg_in (sreg_in), .sreg_step (sreg_step), .busy (busy),
        .seg_valid (seg_valid), .seg_x (seg_x), .seg_y (seg_y),
        .seg_tail (seg_tail), .seg_head (seg_head), .done (done), .hit (hit), .hit_idx (hit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External direction store: entry 0 newest, oldest entry drives sreg_out
    logic [1:0] store    [DEPTH];
    logic [1:0] load_img [DEPTH];
    logic [1:0] snap     [DEPTH];
    logic       load_req = 1'b0;
    assign sreg_out = store[DEPTH-1];

    always @(posedge clk) begin
        if (load_req) begin
            for (int k = 0; k < DEPTH; k++) store[k] <= load_img[k];
        end else if (sreg_step) begin
            for (int k = DEPTH - 1; k > 0; k--) store[k] <= store[k-1];
            store[0] <= sreg_in;
        end
    end

    typedef struct { int x; int y; int tl; int hd; int cy; } seg_t;
    seg_t sb_q[$];

    int n_cmp = 0, n_bad = 0;
    int start_cyc = 0, step_cnt = 0, done_cnt = 0;
    int exp_hit = 0, exp_hit_idx = 0;
    bit mon_en = 1'b0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc - start_cyc);
        end
    endtask

    function automatic int wrap(input int v, input int m);
        return ((v % m) + m) % m;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (sreg_step) step_cnt++;
            check_val("sreg_in", int'(sreg_in), sreg_step ? int'(sreg_out) : 0);
            if (busy) check_val("busy_window", int'((cyc - start_cyc) >= 1 && (cyc - start_cyc) <= DEPTH), 1);
            if (seg_valid) begin
                if (sb_q.size() == 0) begin
                    check_val("seg_extra", 1, 0);
                end else begin
                    seg_t s;
                    s = sb_q.pop_front();
                    check_val("seg_x", int'(seg_x), s.x);
                    check_val("seg_y", int'(seg_y), s.y);
                    check_val("seg_tail", int'(seg_tail), s.tl);
                    check_val("seg_head", int'(seg_head), s.hd);
                    check_val("seg_cycle", cyc - start_cyc, s.cy);
                    $display("seg idx-cycle %0d: (%0d,%0d) tail=%0d head=%0d", cyc - start_cyc,
                             seg_x, seg_y, seg_tail, seg_head);
                end
            end
            if (done) begin
                done_cnt++;
                check_val("done_cycle", cyc - start_cyc, DEPTH + 1);
                check_val("done_busy", int'(busy), 0);
                check_val("hit", int'(hit), exp_hit);
                check_val("hit_idx", int'(hit_idx), exp_hit_idx);
            end
        end
    end

    task automatic do_load();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < DEPTH; k++) load_img[k] = 2'($urandom_range(0, 3));
    endtask

    task automatic run_lap(input int len_in, input int tx, input int ty,
                           input int qx, input int qy, input bit pulses);
        int lc, x, y;
        seg_t s;
        @(negedge clk);
        lc = (len_in < 1) ? 1 : ((len_in > DEPTH + 1) ? DEPTH + 1 : len_in);
        x = tx; y = ty;
        exp_hit = 0; exp_hit_idx = 0;
        s.x = x; s.y = y; s.tl = 1; s.hd = (lc == 1) ? 1 : 0; s.cy = 1;
        sb_q.push_back(s);
        if (x == qx && y == qy) exp_hit = 1;
        for (int j = lc - 2; j >= 0; j--) begin
            case (store[j])
                2'd0: x = wrap(x + 1, GRID_W);
                2'd1: y = wrap(y + 1, GRID_H);
                2'd2: x = wrap(x - 1, GRID_W);
                default: y = wrap(y - 1, GRID_H);
            endcase
            s.x = x; s.y = y; s.tl = 0; s.hd = (j == 0) ? 1 : 0; s.cy = DEPTH - j + 1;
            sb_q.push_back(s);
            if (exp_hit == 0 && x == qx && y == qy) begin
                exp_hit = 1;
                exp_hit_idx = lc - 1 - j;
            end
        end
        step_cnt = 0; done_cnt = 0; start_cyc = cyc;
        len = LEN_W'(len_in); tail_x = XW'(tx); tail_y = YW'(ty);
        qry_x = XW'(qx); qry_y = YW'(qy);
        start = 1'b1;
        for (int c = 1; c <= DEPTH + 3; c++) begin
            @(negedge clk);
            start = pulses && (c == 5 || c == 100);
            if (c == 1) check_val("busy_c1", int'(busy), 1);
        end
        check_val("lap_done_cnt", done_cnt, 1);
        check_val("lap_steps", step_cnt, DEPTH);
        check_val("lap_leftover", sb_q.size(), 0);
        check_val("hit_held", int'(hit), exp_hit);
        sb_q.delete();
        $display("lap len=%0d tail=(%0d,%0d) qry=(%0d,%0d) hit=%0d idx=%0d",
                 len_in, tx, ty, qx, qy, hit, hit_idx);
    endtask

    task automatic check_store(input string tag);
        int diff = 0;
        for (int k = 0; k < DEPTH; k++) if (store[k] !== snap[k]) diff++;
        check_val(tag, diff, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"}, int'(busy), 0);
        check_val({tag, "_step"}, int'(sreg_step), 0);
        check_val({tag, "_sreg_in"}, int'(sreg_in), 0);
        check_val({tag, "_valid"}, int'(seg_valid), 0);
        check_val({tag, "_tail"}, int'(seg_tail), 0);
        check_val({tag, "_head"}, int'(seg_head), 0);
        check_val({tag, "_xy"}, int'({seg_x, seg_y}), 0);
        check_val({tag, "_done"}, int'(done), 0);
        check_val({tag, "_hit"}, int'(hit), 0);
        check_val({tag, "_hit_idx"}, int'(hit_idx), 0);
    endtask

    initial begin
        int idle_bad;
        rst = 1'b1; start = 1'b0; len = '0;
        tail_x = '0; tail_y = '0; qry_x = '0; qry_y = '0;
        fill_random();
        do_load();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");
        mon_en = 1'b1;

        // Single segment: tail is also head and matches the query
        run_lap(1, 5, 5, 5, 5, 1'b0);

        // Straight line of three along +x
        fill_random();
        load_img[0] = 2'd0; load_img[1] = 2'd0;
        do_load();
        run_lap(3, 2, 7, 4, 7, 1'b0);

        // Wrap on +x and on -y
        load_img[0] = 2'd0;
        do_load();
        run_lap(2, 15, 0, 0, 0, 1'b0);
        load_img[0] = 2'd3;
        do_load();
        run_lap(2, 3, 0, 3, 15, 1'b0);

        // Back-to-back laps must leave the store untouched and reproduce the stream
        fill_random();
        do_load();
        for (int k = 0; k < DEPTH; k++) snap[k] = load_img[k];
        run_lap(200, 8, 8, 9, 8, 1'b0);
        check_store("store_lap1");
        run_lap(200, 8, 8, 9, 8, 1'b0);
        check_store("store_lap2");

        // Mid-lap starts are ignored; oversize and zero lengths are clamped
        run_lap(255, 1, 14, 1, 14, 1'b1);
        run_lap(0, 6, 9, 6, 10, 1'b0);
        run_lap($urandom_range(2, 235), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 15), 1'b0);

        // Reset mid-lap: outputs clear the next cycle and no done follows
        mon_en = 1'b0;
        @(negedge clk);
        len = 8'd20; tail_x = 4'd3; tail_y = 4'd3; qry_x = 4'd3; qry_y = 4'd3;
        start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        idle_bad = 0;
        for (int c = 0; c < DEPTH + 5; c++) begin
            @(negedge clk);
            if (busy || done || sreg_step || seg_valid) idle_bad++;
        end
        check_val("midrst_idle", idle_bad, 0);
        mon_en = 1'b1;
        run_lap(4, 10, 2, 10, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
